// File: rtl/debouncer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | debouncer_pkg: shared state encoding and sizing helpers            |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
package debouncer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    function automatic int unsigned clog2(input longint unsigned value);
        int unsigned     r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter must hold DELAY itself, and never collapse to zero bits.
    function automatic int unsigned cnt_width(input int unsigned delay);
        int unsigned w;
        w = clog2(64'(delay) + 64'd1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debouncer_chan.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | debouncer_chan: one debounce channel (FSM, counter, edge pulses)   |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module debouncer_chan
    import debouncer_pkg::*;
#(
    parameter int unsigned DELAY = 32'h0800_0000,
    parameter logic        INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    input  logic tick,
    output logic out_switch,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int unsigned       c_cw    = cnt_width(DELAY);
    localparam logic [c_cw-1:0]   c_delay = c_cw'(DELAY);

    state_t          r_state;
    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            out_switch <= INIT;
            rise       <= 1'b0;
            fall       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (s != out_switch) begin
                        r_state <= ST_COUNT;
                        r_cnt   <= c_delay;
                        busy    <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (s == out_switch) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (tick) begin
                        // Decrement only while non-zero so the counter never wraps.
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            out_switch <= s;
                            rise       <= s;
                            fall       <= ~s;
                            r_state    <= ST_IDLE;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/debouncer_bank.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | debouncer_bank: N-channel debouncer with shared tick prescaler;    |
// | DEBOUNCER_BANK_INPUT_SYNC_EN adds a 2-FF input synchroniser.       |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module debouncer_bank
    import debouncer_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DELAY    = 32'h0800_0000,
    parameter int unsigned TICK_DIV = 1,
    parameter logic [N-1:0] INIT    = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_switch,
    output logic [N-1:0] out_switch,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] busy
);

    logic [N-1:0] w_s;
    logic         w_tick;

`ifdef DEBOUNCER_BANK_INPUT_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    // Reset to INIT so release does not look like a change on every channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= INIT;
            r_sync2 <= INIT;
        end else begin
            r_sync1 <= in_switch;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = in_switch;
`endif

    generate
        if (TICK_DIV <= 1) begin : g_tick_every
            assign w_tick = 1'b1;
        end else begin : g_prescaler
            localparam int unsigned     c_pw   = clog2(TICK_DIV);
            localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);
            logic [c_pw-1:0] r_pre;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pre <= '0;
                end else if (r_pre == c_last) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end

            assign w_tick = (r_pre == c_last);
        end
    endgenerate

    generate
        for (genvar i = 0; i < N; i++) begin : g_chan
            debouncer_chan #(
                .DELAY (DELAY),
                .INIT  (INIT[i])
            ) u_chan (
                .clk        (clk),
                .rst_n      (rst_n),
                .s          (w_s[i]),
                .tick       (w_tick),
                .out_switch (out_switch[i]),
                .rise       (rise[i]),
                .fall       (fall[i]),
                .busy       (busy[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debouncer_bank.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_debouncer_bank: scoreboard bench over three bank configurations |
// | Revision: 1.0                                                      |
// +-------------------------------------------------------------------+
module tb_debouncer_bank;

`ifdef DEBOUNCER_BANK_INPUT_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [3:0] a_in = 4'b1000;
    logic [3:0] a_out, a_rise, a_fall, a_busy;
    logic [1:0] b_in = 2'b00;
    logic [1:0] b_out, b_rise, b_fall, b_busy;
    logic [0:0] c_in = 1'b0;
    logic [0:0] c_out, c_rise, c_fall, c_busy;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] out;
        int         edge_no;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    debouncer_bank #(.N(4), .DELAY(3), .TICK_DIV(1), .INIT(4'b1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_switch(a_in), .out_switch(a_out),
        .rise(a_rise), .fall(a_fall), .busy(a_busy)
    );

    debouncer_bank #(.N(2), .DELAY(2), .TICK_DIV(4), .INIT(2'b00)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_switch(b_in), .out_switch(b_out),
        .rise(b_rise), .fall(b_fall), .busy(b_busy)
    );

    debouncer_bank #(.N(1), .DELAY(0), .TICK_DIV(1), .INIT(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_switch(c_in), .out_switch(c_out),
        .rise(c_rise), .fall(c_fall), .busy(c_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every pulse on dut_a must match the oldest expected commit.
    always @(negedge clk) begin
        if (rst_n && (a_rise != 4'b0 || a_fall != 4'b0)) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected: got rise=%b fall=%b out=%b at edge %0d, required no pulse",
                         a_rise, a_fall, a_out, cyc);
            end else begin
                m_e = q.pop_front();
                if (a_rise !== m_e.rise || a_fall !== m_e.fall || a_out !== m_e.out || cyc !== m_e.edge_no) begin
                    n_fail++;
                    $display("FAIL pulse_commit: got rise=%b fall=%b out=%b edge=%0d, required rise=%b fall=%b out=%b edge=%0d",
                             a_rise, a_fall, a_out, cyc, m_e.rise, m_e.fall, m_e.out, m_e.edge_no);
                end
            end
        end
    end

    task automatic drain(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        ok = (q.size() == 0);
    endtask

    task automatic test_reset();
        bit got;
        int t0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_out !== 4'b1000 || a_busy !== 4'b0 || a_rise !== 4'b0 || a_fall !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_state: got out=%b busy=%b rise=%b fall=%b, required out=1000 busy=0000 rise=0000 fall=0000",
                     a_out, a_busy, a_rise, a_fall);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_in[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_busy[0]) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL reset_busy_start: got busy[0]=0 after 10 cycles, required 1");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_out !== 4'b1000 || a_busy !== 4'b0 || a_rise !== 4'b0 || a_fall !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_midcount: got out=%b busy=%b rise=%b fall=%b, required out=1000 busy=0000 rise=0000 fall=0000",
                     a_out, a_busy, a_rise, a_fall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        repeat (1 + S) @(negedge clk);
        n_checks++;
        if (a_busy !== 4'b0001 || cyc !== t0 + 1 + S) begin
            n_fail++;
            $display("FAIL reset_requalify: got busy=%b at edge %0d, required busy=0001 at edge %0d",
                     a_busy, cyc, t0 + 1 + S);
        end
        a_in[0] = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_busy !== 4'b0 || a_out !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_abort: got busy=%b out=%b, required busy=0000 out=1000", a_busy, a_out);
        end
    endtask

    task automatic test_clean_step();
        int t0;
        int busy_cnt;
        bit others_ok;
        @(negedge clk);
        t0 = cyc;
        a_in[0] = 1'b1;
        q.push_back('{4'b0001, 4'b0000, 4'b1001, t0 + 5 + S});
        busy_cnt  = 0;
        others_ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (a_busy[0]) busy_cnt++;
            if (a_busy[3:1] !== 3'b000 || a_out[3:1] !== 3'b100) others_ok = 1'b0;
        end
        n_checks++;
        if (busy_cnt != 4) begin
            n_fail++;
            $display("FAIL clean_busy_cycles: got %0d, required 4", busy_cnt);
        end
        n_checks++;
        if (!others_ok) begin
            n_fail++;
            $display("FAIL clean_others_untouched: got a change on channels 3..1, required none");
        end
        n_checks++;
        if (q.size() != 0 || a_out !== 4'b1001) begin
            n_fail++;
            $display("FAIL clean_commit: got out=%b pending=%0d, required out=1001 pending=0", a_out, q.size());
        end
    endtask

    task automatic test_bounce();
        int t0;
        int busy_cnt;
        bit ok;
        @(negedge clk);
        a_in[1] = 1'b1;
        busy_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) a_in[1] = 1'b0;
            if (a_busy[1]) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 2) begin
            n_fail++;
            $display("FAIL bounce_busy_cycles: got %0d, required 2", busy_cnt);
        end
        n_checks++;
        if (a_out !== 4'b1001) begin
            n_fail++;
            $display("FAIL bounce_no_commit: got out=%b, required 1001", a_out);
        end
        @(negedge clk);
        t0 = cyc;
        a_in[1] = 1'b1;
        q.push_back('{4'b0010, 4'b0000, 4'b1011, t0 + 5 + S});
        q.push_back('{4'b0000, 4'b0010, 4'b1001, t0 + 10 + S});
        repeat (5) @(negedge clk);
        a_in[1] = 1'b0;
        drain(25, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bounce_pulse_commit: got %0d pending commits, required 0", q.size());
        end
    endtask

    task automatic test_simultaneous();
        int t0;
        bit ok;
        @(negedge clk);
        t0 = cyc;
        a_in = 4'b0101;
        q.push_back('{4'b0100, 4'b1000, 4'b0101, t0 + 5 + S});
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL simultaneous_commit: got %0d pending commits, required 0", q.size());
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        bit ok;
        @(negedge clk);
        t0 = cyc;
        a_in[3] = 1'b1;
        q.push_back('{4'b1000, 4'b0000, 4'b1101, t0 + 5 + S});
        repeat (2) @(negedge clk);
        a_in[1] = 1'b1;
        q.push_back('{4'b0010, 4'b0000, 4'b1111, t0 + 7 + S});
        drain(20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL back_to_back_commit: got %0d pending commits, required 0", q.size());
        end
    endtask

    task automatic test_prescaler();
        int  t0;
        int  e;
        int  k;
        bit  found;
        bit  rise_ok;
        @(negedge clk);
        t0 = cyc;
        b_in[0] = 1'b1;
        e = t0 + 1 + S;
        found = 1'b0;
        rise_ok = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_out[0]) begin
                found   = 1'b1;
                k       = cyc;
                rise_ok = (b_rise === 2'b01);
                break;
            end
        end
        n_checks++;
        if (!found || k - e < 9 || k - e > 13) begin
            n_fail++;
            $display("FAIL prescale_latency: got found=%0d edges=%0d, required 9..13", found, k - e);
        end
        n_checks++;
        if (!rise_ok) begin
            n_fail++;
            $display("FAIL prescale_rise: got rise=%b at commit, required 01", b_rise);
        end
        @(negedge clk);
        t0 = cyc;
        b_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        b_in[1] = 1'b0;
        @(negedge clk);
        b_in[1] = 1'b1;
        repeat (S) @(negedge clk);
        n_checks++;
        if (b_busy[1] !== 1'b0 || b_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL prescale_glitch_abort: got busy=%b out=%b, required busy=0 out=0", b_busy[1], b_out[1]);
        end
        e = t0 + 5 + S;
        found = 1'b0;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b_out[1]) begin
                found = 1'b1;
                k     = cyc;
                break;
            end
        end
        n_checks++;
        if (!found || k - e < 9 || k - e > 13) begin
            n_fail++;
            $display("FAIL prescale_restart_latency: got found=%0d edges=%0d, required 9..13", found, k - e);
        end
    endtask

    task automatic test_delay0();
        int t0;
        int k;
        bit pulse_ok;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            t0 = cyc;
            c_in = (pass == 0) ? 1'b1 : 1'b0;
            k = -1;
            pulse_ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (c_out === c_in) begin
                    k = cyc;
                    pulse_ok = (pass == 0) ? (c_rise === 1'b1 && c_fall === 1'b0)
                                           : (c_fall === 1'b1 && c_rise === 1'b0);
                    break;
                end
            end
            n_checks++;
            if (k != t0 + 2 + S || !pulse_ok) begin
                n_fail++;
                $display("FAIL delay0_commit: pass %0d got edge=%0d pulse_ok=%0d, required edge=%0d pulse_ok=1",
                         pass, k, pulse_ok, t0 + 2 + S);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_prescaler();
        test_delay0();
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending commits, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
- Parametrised N-channel switch debouncer; successor to the single-channel debouncer used on front-panel and board-control inputs of the monitor.
- Per channel it adds a bounce-abort, a shared tick prescaler, one-cycle rise/fall event pulses and a busy flag.
- Sits between raw pins (buttons, jumpers, PSU-good lines) and the register/interrupt logic.

Parameters:
- N, 4, number of independent channels (1..32).
- DELAY, 32'h0800_0000, stable-input count in ticks before commit (>=0).
- TICK_DIV, 1, clk cycles per debounce tick (>=1). 1 means a tick every cycle.
- INIT, {N{1'b0}}, reset value of out_switch per channel.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_switch  input  N  raw switch levels.
- out_switch  output  N  debounced levels.
- rise  output  N  one-cycle pulse when out_switch[i] commits 0->1.
- fall  output  N  one-cycle pulse when out_switch[i] commits 1->0.
- busy  output  N  channel i is qualifying a change (state COUNT).

Behaviour:
- Reset asserted (asynchronous):
  - out_switch=INIT; rise=fall=busy=0.
  - All channels enter IDLE; counters and prescaler are cleared.
  - Takes effect mid-count; the pending change is discarded.
- Reset release: normal operation from the next clk edge. Any input differing from INIT is debounced normally; no instant load.
- Sample s[i]: in_switch[i] directly, or synchronised (see Optional Feature).
- Prescaler:
  - Width clog2(TICK_DIV), free-running 0..TICK_DIV-1.
  - tick=1 in the cycle the count equals TICK_DIV-1; tick is constant 1 when TICK_DIV=1.
- Per-channel FSM, counter width CW=clog2(DELAY+1) (min 1):
  - IDLE: if s!=out, go to COUNT and load counter=DELAY (no tick required). Otherwise stay.
  - COUNT, s==out (bounce back): go to IDLE. No commit, no pulse, counter value is don't-care.
  - COUNT, s!=out, tick, counter!=0: counter-1.
  - COUNT, s!=out, tick, counter==0: out<=s, pulse rise or fall per new level, go to IDLE.
  - COUNT, s!=out, no tick: hold.
- Latency:
  - With TICK_DIV=1, out_switch changes on edge E+DELAY+1, where E is the first edge sampling s!=out.
  - With TICK_DIV>1, the commit falls between DELAY*TICK_DIV+1 and (DELAY+1)*TICK_DIV+1 edges after E.
- Pulses:
  - rise/fall are registered and high exactly one cycle, coincident with the first cycle of the new out_switch.
  - rise and fall are never both high on one channel.
- busy[i] = (state==COUNT), registered.
- Channels are fully independent. Simultaneous changes on any subset commit in the same cycle when their conditions coincide.
- DELAY=0: a commit needs one tick in COUNT.
- The counter never wraps: it is only decremented when non-zero.

Optional Feature:
- Macro: DEBOUNCER_BANK_INPUT_SYNC_EN.
- Defined: each in_switch bit passes through a 2-FF synchroniser reset to INIT. s is the second-stage output, and all latencies grow by 2 cycles.
- Undefined: in_switch is used directly and must be synchronous to clk. No extra flops.

Decomposition:
- Package debouncer_pkg:
  - state encoding (ST_IDLE=1'b0, ST_COUNT=1'b1);
  - clog2 constant function;
  - sizing helper giving CW from DELAY.
- Sub-module debouncer_chan: one channel (FSM, counter, out, rise/fall/busy), with parameters DELAY and INIT bit, and inputs clk, rst_n, s, tick.
- debouncer_bank owns the prescaler and the optional synchroniser, and instantiates N debouncer_chan via generate.

Test Plan:
1. Reset: N=4, DELAY=3, INIT=4'b1000. Drop rst_n asynchronously while ch0 is busy -> out=4'b1000, busy=0, rise=fall=0 before the next clk edge; ch0 restarts qualification after release.
2. Clean step: in[0] 0->1 and held, TICK_DIV=1 -> out[0]=1 exactly 4 edges after first sampling, rise[0]=1 for one cycle, busy[0] high for 4 cycles, other channels untouched.
3. Bounce abort: in[1] high for 2 cycles then low -> out[1] stays 0, no rise/fall, busy[1] 1 for 2 cycles then 0. A later 5-cycle high pulse commits once.
4. Simultaneous events: INIT=4'b1000, in 4'b0000->4'b0100 on the same edge (ch2 0->1, ch3 1->0) -> both commit on the same edge, rise=4'b0100, fall=4'b1000.
5. Prescaler: TICK_DIV=4, DELAY=2, step held -> commit between 9 and 13 edges after first sampling; a glitch of 1 cycle inside a tick window aborts.
6. DEBOUNCER_BANK_INPUT_SYNC_EN defined, scenario 2 repeated -> commit at 6 edges; DELAY=0 -> commit on the first tick after entering COUNT.
